// File: rtl/rom_player_if.sv
// Handshake bundle for rom_player: run request, streamed word output and status.
// The loop/stop controls exist only when ROM_PLAYER_LOOP_EN is defined.
interface rom_player_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] len;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef ROM_PLAYER_LOOP_EN
  logic              loop;
  logic              stop;
`endif

  modport master (
`ifdef ROM_PLAYER_LOOP_EN
    input  loop,
    input  stop,
`endif
    input  start,
    input  start_addr,
    input  len,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    output busy,
    output done
  );

  modport slave (
`ifdef ROM_PLAYER_LOOP_EN
    output loop,
    output stop,
`endif
    output start,
    output start_addr,
    output len,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    input  busy,
    input  done
  );
endinterface

// File: rtl/rom_player.sv
// Lookup ROM (mem[i] = i*STEP mod 2^DATA_W) with an address sequencer streaming a run of words.
// Optional ROM_PLAYER_LOOP_EN: runs repeat from the latched start until a stop pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs idle
// FETCH | ROM word for addr_q registered into output regs
// SEND  | word presented with out_valid, waiting for out_ready
module rom_player #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int STEP   = 2
) (
  input logic         clk,
  input logic         rst,
  rom_player_if.master bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
`ifdef ROM_PLAYER_LOOP_EN
  logic [ADDR_W-1:0] base_addr_q, base_addr_d;
  logic [ADDR_W-1:0] base_len_q, base_len_d;
  logic              loop_q, loop_d;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign mem[i] = DATA_W'(i * STEP);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef ROM_PLAYER_LOOP_EN
    base_addr_d = base_addr_q;
    base_len_d  = base_len_q;
    loop_d      = loop_q & ~bus.stop;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = bus.start_addr;
          rem_d   = bus.len;
          state_d = FETCH;
`ifdef ROM_PLAYER_LOOP_EN
          base_addr_d = bus.start_addr;
          base_len_d  = bus.len;
          loop_d      = bus.loop;
`endif
        end
      end
      FETCH: begin
        data_d  = mem[addr_q];
        oaddr_d = addr_q;
        last_d  = (rem_q == '0);
        state_d = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          if (!last_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - ADDR_W'(1);
            state_d = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef ROM_PLAYER_LOOP_EN
            // A stop arriving on the final handshake still ends this pass.
            if (loop_d) begin
              addr_d  = base_addr_q;
              rem_d   = base_len_q;
              state_d = FETCH;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ROM_PLAYER_LOOP_EN
      base_addr_q <= '0;
      base_len_q  <= '0;
      loop_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef ROM_PLAYER_LOOP_EN
      base_addr_q <= base_addr_d;
      base_len_q  <= base_len_d;
      loop_q      <= loop_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_addr  = oaddr_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_rom_player.sv
// Bench for rom_player: vector table of runs with a scoreboard monitor, plus reset, parameter and loop sequences.
module tb_rom_player;
  logic clk;
  logic rst;

  rom_player_if #(.ADDR_W(3), .DATA_W(4)) bus ();
  rom_player_if #(.ADDR_W(4), .DATA_W(5)) bus_p ();

  rom_player #(.ADDR_W(3), .DATA_W(4), .STEP(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  rom_player #(.ADDR_W(4), .DATA_W(5), .STEP(3)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    int sa;
    int len;
    int stall_idx;
    int stall_n;
    int ign_idx;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  logic       exp_done = 1'b0;
  logic       stalled  = 1'b0;
  logic [3:0] held_data;
  logic [2:0] held_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    chk("done_pulse", {31'b0, bus.done}, {31'b0, exp_done});
    exp_done = 1'b0;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_data", {28'b0, bus.out_data}, {28'b0, held_data});
        chk("hold_addr", {29'b0, bus.out_addr}, {29'b0, held_addr});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {29'b0, bus.out_addr}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("word_data", {28'b0, bus.out_data}, {28'b0, e.data});
          chk("word_addr", {29'b0, bus.out_addr}, {29'b0, e.addr});
          chk("word_last", {31'b0, bus.out_last}, {31'b0, e.last});
          exp_done = e.last;
        end
      end
      stalled   = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_addr = bus.out_addr;
    end
  end

  task automatic push_run(input int sa, input int len);
    exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.addr = 3'((sa + i) % 8);
      e.data = 4'((((sa + i) % 8) * 2) % 16);
      e.last = (i == len);
      sb.push_back(e);
    end
  endtask

  task automatic run_main(input vec_t v);
    int w;
    int guard;
    push_run(v.sa, v.len);
    bus.out_ready  = 1'b1;
    bus.start      = 1'b1;
    bus.start_addr = 3'(v.sa);
    bus.len        = 3'(v.len);
    cyc();
    bus.start = 1'b0;
    chk("busy_after_start", {31'b0, bus.busy}, 32'd1);
    chk("valid_in_fetch", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    chk("first_valid_latency", {31'b0, bus.out_valid}, 32'd1);
    w = 0;
    guard = 0;
    while (w <= v.len && guard < 200) begin
      if (bus.out_valid) begin
        if (w == v.ign_idx) begin
          bus.start      = 1'b1;
          bus.start_addr = 3'd5;
          bus.len        = 3'd7;
        end
        if (w == v.stall_idx) begin
          bus.out_ready = 1'b0;
          repeat (v.stall_n) cyc();
          bus.out_ready = 1'b1;
        end
        w++;
      end
      cyc();
      bus.start = 1'b0;
      guard++;
    end
    chk("run_timeout", guard < 200 ? 32'd1 : 32'd0, 32'd1);
    chk("busy_after_last", {31'b0, bus.busy}, 32'd0);
    chk("valid_after_last", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    chk("words_outstanding", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    int w;
    int guard;
    logic [4:0] pdata [3];
    logic [3:0] paddr [3];

    vecs[0] = '{sa: 2, len: 2, stall_idx: -1, stall_n: 0, ign_idx: -1};
    vecs[1] = '{sa: 6, len: 3, stall_idx: -1, stall_n: 0, ign_idx: -1};
    vecs[2] = '{sa: 0, len: 3, stall_idx: 1,  stall_n: 5, ign_idx: -1};
    vecs[3] = '{sa: 0, len: 1, stall_idx: -1, stall_n: 0, ign_idx: 0};
    vecs[4] = '{sa: 5, len: 7, stall_idx: 3,  stall_n: 2, ign_idx: 6};
    vecs[5] = '{sa: 7, len: 0, stall_idx: 0,  stall_n: 3, ign_idx: -1};

    pdata = '{5'd10, 5'd13, 5'd0};
    paddr = '{4'd14, 4'd15, 4'd0};

    rst = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.len = '0; bus.out_ready = 1'b1;
    bus_p.start = 1'b0; bus_p.start_addr = '0; bus_p.len = '0; bus_p.out_ready = 1'b1;
`ifdef ROM_PLAYER_LOOP_EN
    bus.loop = 1'b0; bus.stop = 1'b0;
    bus_p.loop = 1'b0; bus_p.stop = 1'b0;
`endif
    repeat (2) cyc();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_data", {28'b0, bus.out_data}, 32'd0);
    chk("rst_addr", {29'b0, bus.out_addr}, 32'd0);
    chk("rst_last", {31'b0, bus.out_last}, 32'd0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) run_main(vecs[i]);

    // Reset after the first handshake of a long run.
    push_run(3, 7);
    bus.start = 1'b1; bus.start_addr = 3'd3; bus.len = 3'd7;
    cyc();
    bus.start = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin cyc(); guard++; end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_data", {28'b0, bus.out_data}, 32'd0);
    chk("midrst_last", {31'b0, bus.out_last}, 32'd0);
    repeat (3) cyc();
    chk("midrst_idle", {31'b0, bus.busy | bus.out_valid}, 32'd0);
    run_main(vecs[0]);

    // Wider parameter set on the second instance.
    bus_p.start = 1'b1; bus_p.start_addr = 4'd14; bus_p.len = 4'd2;
    cyc();
    bus_p.start = 1'b0;
    w = 0;
    guard = 0;
    while (w < 3 && guard < 50) begin
      if (bus_p.out_valid) begin
        chk("p_data", {27'b0, bus_p.out_data}, {27'b0, pdata[w]});
        chk("p_addr", {28'b0, bus_p.out_addr}, {28'b0, paddr[w]});
        chk("p_last", {31'b0, bus_p.out_last}, (w == 2) ? 32'd1 : 32'd0);
        w++;
      end
      cyc();
      guard++;
    end
    chk("p_timeout", guard < 50 ? 32'd1 : 32'd0, 32'd1);
    chk("p_done", {31'b0, bus_p.done}, 32'd1);
    chk("p_busy", {31'b0, bus_p.busy}, 32'd0);
    cyc();
    chk("p_done_one_cycle", {31'b0, bus_p.done}, 32'd0);

`ifdef ROM_PLAYER_LOOP_EN
    // Looping pass: three passes, stop pulsed during the third.
    push_run(6, 1); push_run(6, 1); push_run(6, 1);
    bus.start = 1'b1; bus.start_addr = 3'd6; bus.len = 3'd1; bus.loop = 1'b1;
    cyc();
    bus.start = 1'b0; bus.loop = 1'b0;
    w = 0;
    guard = 0;
    while (w < 6 && guard < 100) begin
      bus.stop = 1'b0;
      if (bus.out_valid) begin
        w++;
        if (w == 5) bus.stop = 1'b1;
      end
      cyc();
      guard++;
    end
    bus.stop = 1'b0;
    chk("loop_timeout", guard < 100 ? 32'd1 : 32'd0, 32'd1);
    chk("loop_busy_end", {31'b0, bus.busy}, 32'd0);
    cyc();
    chk("loop_words_left", sb.size(), 32'd0);
    sb.delete();
`endif

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rom_player.md
# rom_player

Parametrised lookup ROM with a built-in address sequencer that streams a contiguous run of words out over a valid/ready interface. Contents are generated at elaboration as `mem[i] = (i*STEP) mod 2^DATA_W`. The default parameters give the team's 8x4 even-number table. The block replaces ad-hoc combinational ROM reads in the lab datapaths, and feeds display and arithmetic stages that may apply backpressure.

## Interface
- `ADDR_W`, default 3: address width; depth is `DEPTH = 2^ADDR_W`.
- `DATA_W`, default 4: word width.
- `STEP`, default 2: content generator; `mem[i] = (i*STEP)` truncated to `DATA_W` bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a run; sampled only in IDLE.
- `start_addr` input ADDR_W: first address of the run; sampled with `start`.
- `len` input ADDR_W: run length minus one, so a run is `len+1` words (1..DEPTH); sampled with `start`.
- `out_valid` output 1: `out_data`, `out_addr` and `out_last` are valid.
- `out_ready` input 1: consumer accepts the word when high in the same cycle as `out_valid`.
- `out_data` output DATA_W: ROM word.
- `out_addr` output ADDR_W: address of `out_data`.
- `out_last` output 1: the current word is the final word of the run.
- `busy` output 1: a run is in progress (state is not IDLE).
- `done` output 1: one-cycle pulse after the last word is accepted.

## Operation
- The FSM has three states: IDLE, FETCH and SEND.
- IDLE: when `start`=1, latch `start_addr` into the address register and `len` into the remaining-count register, then go to FETCH. When `start`=0, stay in IDLE.
- FETCH: register `mem[addr]`, `addr` and `last = (remaining==0)` into the output registers, then go to SEND. `out_valid` is 0 in this state.
- SEND: `out_valid`=1.
  - While `out_ready`=0, stay in SEND; the outputs are held stable.
  - On a handshake (`out_valid & out_ready`) with `out_last`=0: increment `addr` modulo DEPTH, decrement `remaining`, go to FETCH.
  - On a handshake with `out_last`=1: go to IDLE and pulse `done`.
- The address wraps from DEPTH-1 to 0, because the increment is an ADDR_W-bit add with the carry discarded.
- `start` while `busy`=1 is ignored; it is not queued.
- With `len`=DEPTH-1 the run covers every address exactly once, beginning at `start_addr`.
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0, internal address and count registers 0.
- Reset asserted mid-run aborts the run at the next edge. No `done` is produced and no further words are output.

## Timing
- If `start` is sampled at edge T, state is FETCH after T, and `out_valid`=1 with the first word after edge T+1.
- If a non-last handshake occurs at edge H, `out_valid` is 0 for one cycle after H, and the next word is valid after edge H+1. Peak throughput is therefore one word per 2 cycles.
- If the last handshake occurs at edge H, then after H: `done`=1 for exactly one cycle, `busy`=0, `out_valid`=0. A new `start` is accepted at edge H+1.
- `busy` is registered and goes high in the cycle after `start` is sampled.
- ROM read latency is 1 cycle (FETCH). There is no combinational path from `out_ready` to any output.

## Configuration
- `ROM_PLAYER_LOOP_EN` defined:
  - Adds input `loop` (1 bit), sampled together with `start`.
  - If the latched `loop`=1, the last handshake reloads `start_addr` and `len`, with the values latched at start, and goes to FETCH instead of IDLE. `done` pulses at the end of each pass, `busy` stays 1, and `out_last` still marks each pass's final word.
  - An input `stop` pulse (also added) clears the latched loop flag, so the current pass ends normally.
- `ROM_PLAYER_LOOP_EN` undefined: the `loop` and `stop` ports do not exist, and every run ends in IDLE.

## Test plan
- Basic run with defaults, `out_ready`=1: `start_addr`=2, `len`=2 -> `out_data` 4, 6, 8 at `out_addr` 2, 3, 4; `out_last` only on 8; `done` one cycle after the 8 is accepted; first `out_valid` 2 cycles after `start`.
- Wrap: `start_addr`=6, `len`=3 -> addresses 6, 7, 0, 1 and data 12, 14, 0, 2.
- Backpressure: `out_ready` low for 5 cycles during the second word of run 0..3 -> `out_data`=2, `out_addr`=1 and `out_valid`=1 held stable; the sequence resumes with 4, 6 and no word is lost or duplicated.
- `start` pulsed with `start_addr`=5 while `busy` -> ignored; the run from 0 with `len`=1 completes with 0, 2 only.
- Reset mid-run: `rst` asserted after the first handshake of run 0..7 -> the next cycle shows `out_valid`=0, `busy`=0, `out_data`=0, and no `done`; a fresh `start` afterwards works normally.
- Parameter sweep `ADDR_W`=4, `DATA_W`=5, `STEP`=3, `start_addr`=14, `len`=2 -> data 10 (42 mod 32), 13 (45 mod 32), 0; addresses 14, 15, 0. With `ROM_PLAYER_LOOP_EN`, `loop`=1 -> the pattern repeats with `done` at each pass until `stop`.
